// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, opcode enum, instruction layout and the
//               built-in ROM image for the 8-bit teaching CPU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DW          = 8;
    localparam int IW          = 9;
    localparam int PCW         = 8;
    localparam int C_NREGS     = 8;
    localparam int C_ROM_DEPTH = 1 << PCW;
    localparam int C_DM_DEPTH  = 1 << DW;
    localparam int C_ROM_BITS  = C_ROM_DEPTH * IW;

    typedef enum logic [2:0] {
        OP_MOVI = 3'b000,
        OP_LD   = 3'b001,
        OP_ST   = 3'b010,
        OP_AND  = 3'b011,
        OP_ADD  = 3'b100,
        OP_XOR  = 3'b101,
        OP_BNZ  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef struct packed {
        opcode_e    op;
        logic [2:0] rd;
        logic [2:0] rs;
    } instr_t;

    function automatic logic [IW-1:0] enc(input opcode_e op, input logic [2:0] rd,
                                          input logic [2:0] rs);
        return {op, rd, rs};
    endfunction

    function automatic logic [C_ROM_BITS-1:0] halt_image();
        logic [C_ROM_BITS-1:0] img;
        img = '0;
        for (int i = 0; i < C_ROM_DEPTH; i++) begin
            img[i*IW +: IW] = enc(OP_HALT, 3'd0, 3'd0);
        end
        return img;
    endfunction

    // dm[2] = dm[0] & dm[1]
    function automatic logic [C_ROM_BITS-1:0] builtin_prog();
        logic [C_ROM_BITS-1:0] img;
        img = halt_image();
        img[0*IW +: IW] = enc(OP_MOVI, 3'd0, 3'd0);
        img[1*IW +: IW] = enc(OP_MOVI, 3'd1, 3'd1);
        img[2*IW +: IW] = enc(OP_MOVI, 3'd2, 3'd2);
        img[3*IW +: IW] = enc(OP_LD,   3'd3, 3'd0);
        img[4*IW +: IW] = enc(OP_LD,   3'd4, 3'd1);
        img[5*IW +: IW] = enc(OP_AND,  3'd3, 3'd4);
        img[6*IW +: IW] = enc(OP_ST,   3'd3, 3'd2);
        img[7*IW +: IW] = enc(OP_HALT, 3'd0, 3'd0);
        return img;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Two-operand ALU for AND / ADD / XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import cpu_pkg::*;
(
    input  opcode_e       i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_y
);

    always_comb begin
        o_y = i_b;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_ADD:  o_y = i_a + i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = i_b;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : 256 x 8 data memory, async read, sync write, never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          i_we,
    input  logic [DW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] core [0:C_DM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            core[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = core[i_addr];

endmodule
`default_nettype wire

// File: rtl/instr_rom.sv
`default_nettype none
// ============================================================================
// Module      : instr_rom
// Description : Combinational 256 x 9 instruction ROM holding a fixed image.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_rom
    import cpu_pkg::*;
#(
    parameter logic [C_ROM_BITS-1:0] PROG = builtin_prog()
) (
    input  logic [PCW-1:0] i_addr,
    output logic [IW-1:0]  o_instr
);

    assign o_instr = PROG[i_addr*IW +: IW];

endmodule
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter; steps by one or by a signed branch offset.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic           i_branch,
    input  logic [PCW-1:0] i_off,
    output logic [PCW-1:0] o_pc
);

    logic [PCW-1:0] r_pc;

    // Modular add gives the 255->0 wrap and backward branches for free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_en) begin
            r_pc <= r_pc + (i_branch ? i_off : PCW'(1));
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 8 x 8 register file, two async read ports, one write port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    i_ra_addr,
    input  logic [2:0]    i_rb_addr,
    input  logic          i_we,
    input  logic [2:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_ra_data,
    output logic [DW-1:0] o_rb_data
);

    logic [DW-1:0] core [0:C_NREGS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_NREGS; i++) begin
                core[i] <= '0;
            end
        end else if (i_we) begin
            core[i_waddr] <= i_wdata;
        end
    end

    assign o_ra_data = core[i_ra_addr];
    assign o_rb_data = core[i_rb_addr];

endmodule
`default_nettype wire

// File: rtl/top_level_cpu.sv
`default_nettype none
// ============================================================================
// Module      : top_level_cpu
// Description : 8-bit single-cycle CPU; runs its ROM from PC=0, flags done on HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module top_level_cpu #(
    parameter int DW  = cpu_pkg::DW,
    parameter int IW  = cpu_pkg::IW,
    parameter int PCW = cpu_pkg::PCW,
    parameter logic [cpu_pkg::C_ROM_BITS-1:0] PROG = cpu_pkg::builtin_prog()
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    import cpu_pkg::*;

    logic [PCW-1:0] w_pc;
    logic [PCW-1:0] w_off;
    logic [IW-1:0]  w_rom_word;
    instr_t         w_instr;
    logic [DW-1:0]  w_rd_val;
    logic [DW-1:0]  w_rs_val;
    logic [DW-1:0]  w_alu_y;
    logic [DW-1:0]  w_mem_rdata;
    logic [DW-1:0]  w_wb_data;
    logic           w_run;
    logic           w_rf_we;
    logic           w_dm_we;
    logic           w_branch;
    logic           r_done;

    assign w_instr  = instr_t'(w_rom_word);
    // HALT (or a latched done) freezes the PC and blocks every write
    assign w_run    = !r_done && (w_instr.op != OP_HALT);
    assign w_dm_we  = w_run && (w_instr.op == OP_ST);
    assign w_branch = w_run && (w_instr.op == OP_BNZ) && (w_rd_val != '0);
    assign w_off    = {{(PCW-3){w_instr.rs[2]}}, w_instr.rs};

    always_comb begin
        w_rf_we   = 1'b0;
        w_wb_data = w_alu_y;
        case (w_instr.op)
            OP_MOVI: begin
                w_rf_we   = w_run;
                w_wb_data = {{(DW-3){1'b0}}, w_instr.rs};
            end
            OP_LD: begin
                w_rf_we   = w_run;
                w_wb_data = w_mem_rdata;
            end
            OP_AND, OP_ADD, OP_XOR: begin
                w_rf_we   = w_run;
                w_wb_data = w_alu_y;
            end
            default: begin
                w_rf_we   = 1'b0;
                w_wb_data = w_alu_y;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_instr.op == OP_HALT) begin
            r_done <= 1'b1;
        end
    end

    assign done = r_done;

    pc_reg pc1 (
        .clk      (clk),
        .rst      (reset),
        .i_en     (w_run),
        .i_branch (w_branch),
        .i_off    (w_off),
        .o_pc     (w_pc)
    );

    instr_rom #(
        .PROG (PROG)
    ) rom1 (
        .i_addr  (w_pc),
        .o_instr (w_rom_word)
    );

    reg_file rf1 (
        .clk       (clk),
        .rst       (reset),
        .i_ra_addr (w_instr.rd),
        .i_rb_addr (w_instr.rs),
        .i_we      (w_rf_we),
        .i_waddr   (w_instr.rd),
        .i_wdata   (w_wb_data),
        .o_ra_data (w_rd_val),
        .o_rb_data (w_rs_val)
    );

    alu alu1 (
        .i_op (w_instr.op),
        .i_a  (w_rd_val),
        .i_b  (w_rs_val),
        .o_y  (w_alu_y)
    );

    data_mem dm1 (
        .clk     (clk),
        .i_we    (w_dm_we),
        .i_addr  (w_rs_val),
        .i_wdata (w_rd_val),
        .o_rdata (w_mem_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_top_level_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_level_cpu
// Description : Scoreboard bench: built-in program plus ALU/BNZ/PC-wrap images.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_level_cpu;
    import cpu_pkg::*;

    typedef struct {
        int         dsel;
        int         kind;   // 0 = dm word, 1 = rf word, 2 = pc
        int         idx;
        logic [7:0] exp;
    } exp_t;

    function automatic logic [C_ROM_BITS-1:0] mk_alu();
        logic [C_ROM_BITS-1:0] img;
        img = halt_image();
        img[0*IW +: IW]  = enc(OP_MOVI, 3'd0, 3'd0);
        img[1*IW +: IW]  = enc(OP_MOVI, 3'd1, 3'd1);
        img[2*IW +: IW]  = enc(OP_LD,   3'd2, 3'd0);
        img[3*IW +: IW]  = enc(OP_LD,   3'd3, 3'd1);
        img[4*IW +: IW]  = enc(OP_ADD,  3'd2, 3'd3);
        img[5*IW +: IW]  = enc(OP_MOVI, 3'd4, 3'd2);
        img[6*IW +: IW]  = enc(OP_ST,   3'd2, 3'd4);
        img[7*IW +: IW]  = enc(OP_XOR,  3'd3, 3'd2);
        img[8*IW +: IW]  = enc(OP_MOVI, 3'd5, 3'd3);
        img[9*IW +: IW]  = enc(OP_ST,   3'd3, 3'd5);
        return img;
    endfunction

    function automatic logic [C_ROM_BITS-1:0] mk_bnz();
        logic [C_ROM_BITS-1:0] img;
        img = halt_image();
        img[0*IW +: IW] = enc(OP_MOVI, 3'd1, 3'd0);
        img[1*IW +: IW] = enc(OP_BNZ,  3'd1, 3'd3);
        img[2*IW +: IW] = enc(OP_MOVI, 3'd2, 3'd5);
        img[3*IW +: IW] = enc(OP_BNZ,  3'd2, 3'd2);
        img[4*IW +: IW] = enc(OP_MOVI, 3'd3, 3'd7);
        return img;
    endfunction

    function automatic logic [C_ROM_BITS-1:0] mk_wrap();
        logic [C_ROM_BITS-1:0] img;
        img = halt_image();
        img[0*IW +: IW]   = enc(OP_BNZ,  3'd6, 3'd3);
        img[1*IW +: IW]   = enc(OP_MOVI, 3'd7, 3'd1);
        img[2*IW +: IW]   = enc(OP_BNZ,  3'd7, 3'b101);
        img[255*IW +: IW] = enc(OP_MOVI, 3'd6, 3'd5);
        return img;
    endfunction

    localparam logic [C_ROM_BITS-1:0] P_ALU  = mk_alu();
    localparam logic [C_ROM_BITS-1:0] P_BNZ  = mk_bnz();
    localparam logic [C_ROM_BITS-1:0] P_WRAP = mk_wrap();

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    logic done_a, done_b, done_c, done_d;
    logic [3:0] w_done;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    assign w_done = {done_d, done_c, done_b, done_a};

    top_level_cpu dut (.clk(clk), .reset(rst_a), .done(done_a));
    top_level_cpu #(.PROG(P_ALU))  dut_alu  (.clk(clk), .reset(rst_b), .done(done_b));
    top_level_cpu #(.PROG(P_BNZ))  dut_bnz  (.clk(clk), .reset(rst_c), .done(done_c));
    top_level_cpu #(.PROG(P_WRAP)) dut_wrap (.clk(clk), .reset(rst_d), .done(done_d));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] actual(input int d, input int kind, input int idx);
        logic [7:0] a;
        logic [2:0] r;
        a = idx[7:0];
        r = idx[2:0];
        case (d)
            0: return (kind == 0) ? dut.dm1.core[a] : (kind == 1) ? dut.rf1.core[r] : dut.w_pc;
            1: return (kind == 0) ? dut_alu.dm1.core[a] : (kind == 1) ? dut_alu.rf1.core[r] : dut_alu.w_pc;
            2: return (kind == 0) ? dut_bnz.dm1.core[a] : (kind == 1) ? dut_bnz.rf1.core[r] : dut_bnz.w_pc;
            default: return (kind == 0) ? dut_wrap.dm1.core[a] : (kind == 1) ? dut_wrap.rf1.core[r] : dut_wrap.w_pc;
        endcase
    endfunction

    task automatic poke(input int d, input int idx, input logic [7:0] v);
        logic [7:0] a;
        a = idx[7:0];
        case (d)
            0:       dut.dm1.core[a] = v;
            1:       dut_alu.dm1.core[a] = v;
            2:       dut_bnz.dm1.core[a] = v;
            default: dut_wrap.dm1.core[a] = v;
        endcase
    endtask

    task automatic set_rst(input int d, input logic v);
        case (d)
            0:       rst_a = v;
            1:       rst_b = v;
            2:       rst_c = v;
            default: rst_d = v;
        endcase
    endtask

    task automatic expect_val(input int d, input int kind, input int idx, input logic [7:0] v);
        exp_t e;
        e.dsel = d; e.kind = kind; e.idx = idx; e.exp = v;
        sb.push_back(e);
    endtask

    // Monitor: on each rising done, drain that DUT's expectations
    initial begin : monitor
        logic [3:0] done_q;
        exp_t e;
        done_q = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (w_done[d] && !done_q[d]) begin
                    while (sb.size() > 0 && sb[0].dsel == d) begin
                        e = sb.pop_front();
                        chk($sformatf("dut%0d kind%0d[%0d]", d, e.kind, e.idx),
                            actual(d, e.kind, e.idx), e.exp);
                    end
                end
            end
            done_q = w_done;
        end
    end

    // Reset is already asserted by the caller; expectations already pushed
    task automatic run(input int d, input int exp_edges, input logic [7:0] dm2_at7);
        int edges;
        exp_t e;
        @(negedge clk);
        chk($sformatf("dut%0d reset pc", d), actual(d, 2, 0), 8'h00);
        chk($sformatf("dut%0d reset done", d), {7'd0, w_done[d]}, 8'h00);
        chk($sformatf("dut%0d reset r1", d), actual(d, 1, 1), 8'h00);
        set_rst(d, 1'b0);
        edges = 0;
        while (!w_done[d] && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (exp_edges > 0 && edges == 7) begin
                chk("dm2 at edge 7", actual(d, 0, 2), dm2_at7);
                chk("done low at edge 7", {7'd0, w_done[d]}, 8'h00);
            end
        end
        if (exp_edges > 0) chk("done edge count", edges[7:0], exp_edges[7:0]);
        repeat (3) @(negedge clk);
        chk($sformatf("dut%0d done held", d), {7'd0, w_done[d]}, 8'h01);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL no-done dut%0d kind%0d[%0d]: got none expected %02h",
                     e.dsel, e.kind, e.idx, e.exp);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        repeat (2) @(negedge clk);

        // Built-in program, three data patterns
        poke(0, 0, 8'h00); poke(0, 1, 8'h1E); poke(0, 2, 8'hAA);
        expect_val(0, 0, 2, 8'h00); expect_val(0, 2, 0, 8'h07);
        run(0, 0, 8'h00);

        set_rst(0, 1'b1);
        poke(0, 0, 8'hC3); poke(0, 1, 8'h55); poke(0, 2, 8'h00);
        expect_val(0, 0, 2, 8'h41); expect_val(0, 1, 3, 8'h41); expect_val(0, 1, 4, 8'h55);
        run(0, 0, 8'h00);

        set_rst(0, 1'b1);
        poke(0, 0, 8'hFF); poke(0, 1, 8'hFF); poke(0, 2, 8'h00);
        expect_val(0, 0, 2, 8'hFF);
        run(0, 8, 8'hFF);

        // Reset mid-program after four edges
        set_rst(0, 1'b1);
        poke(0, 0, 8'h3C); poke(0, 1, 8'h0F); poke(0, 2, 8'h99);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid pc before reset", dut.w_pc, 8'h04);
        chk("mid r1 before reset", dut.rf1.core[1], 8'h01);
        #1;
        rst_a = 1'b1;
        #1;
        chk("mid async pc", dut.w_pc, 8'h00);
        chk("mid async done", {7'd0, done_a}, 8'h00);
        chk("mid async r1", dut.rf1.core[1], 8'h00);
        chk("mid dm survives", dut.dm1.core[0], 8'h3C);
        expect_val(0, 0, 2, 8'h0C); expect_val(0, 2, 0, 8'h07);
        run(0, 8, 8'h0C);

        // Quiescence after done
        repeat (20) @(negedge clk);
        chk("hold pc", dut.w_pc, 8'h07);
        chk("hold done", {7'd0, done_a}, 8'h01);
        chk("hold dm2", dut.dm1.core[2], 8'h0C);
        chk("hold r3", dut.rf1.core[3], 8'h0C);
        chk("hold r4", dut.rf1.core[4], 8'h0F);

        // ADD overflow and XOR
        poke(1, 0, 8'hF0); poke(1, 1, 8'h20); poke(1, 2, 8'h00); poke(1, 3, 8'h00);
        expect_val(1, 0, 2, 8'h10); expect_val(1, 0, 3, 8'h30);
        expect_val(1, 1, 2, 8'h10); expect_val(1, 2, 0, 8'h0A);
        run(1, 0, 8'h00);

        // BNZ not taken then taken
        expect_val(2, 1, 2, 8'h05); expect_val(2, 1, 3, 8'h00); expect_val(2, 2, 0, 8'h05);
        run(2, 0, 8'h00);

        // Backward branch to 255, wrap to 0
        expect_val(3, 1, 6, 8'h05); expect_val(3, 1, 7, 8'h01); expect_val(3, 2, 0, 8'h03);
        run(3, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
